// File: rtl/apb_master_controller_if.sv
// ---------------------------------------------------------------------------
// apb_master_controller_if
// Bundles the AHB-side request signals and the APB bus driven by the
// APB-side initiator of the AHB-to-APB bridge.
//
// Signals:
//   valid      AHB address phase accepted this cycle
//   haddr      live AHB address
//   hwrite     live AHB write flag
//   hwdata     live AHB write data (data phase)
//   tempselx   one-hot peripheral decode of haddr
//   pready     APB completer ready
//   hreadyout  AHB ready back to the AHB master
//   pselx      APB selects
//   penable    APB enable
//   pwrite     APB direction
//   paddr      APB address
//   pwdata     APB write data
//
// Modports:
//   master  view of the APB initiator (drives the APB bus and hreadyout)
//   slave   view of everything around it (AHB side and APB completers)
// ---------------------------------------------------------------------------
interface apb_master_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
);
    logic              valid;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [DATA_W-1:0] hwdata;
    logic [NSEL-1:0]   tempselx;
    logic              pready;
    logic              hreadyout;
    logic [NSEL-1:0]   pselx;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;

    modport master (
        input  valid, haddr, hwrite, hwdata, tempselx, pready,
        output hreadyout, pselx, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output valid, haddr, hwrite, hwdata, tempselx, pready,
        input  hreadyout, pselx, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_controller.sv
// ---------------------------------------------------------------------------
// apb_master_controller
// APB-side initiator of the AHB-to-APB bridge. Turns an accepted AHB
// address phase into a two-phase SETUP/ACCESS APB transfer and stretches the
// AHB data phase through hreadyout until the APB transfer completes.
// Writes take an extra WWAIT cycle so the AHB write data (which arrives one
// cycle after the address) can be captured. Back-to-back transfers chain
// straight from the completing ACCESS cycle into the next transfer.
//
// Ports:
//   clk   bridge clock, rising edge
//   rst   synchronous active-high reset
//   bus   apb_master_controller_if.master (AHB request in, APB bus out)
//
// Configuration macro:
//   APB_PREADY_EN  defined: ACCESS waits on pready and hreadyout follows it
//                  undefined: pready is ignored, ACCESS lasts one cycle
//
// state  | meaning
// IDLE   | no transfer, hreadyout=1, waiting for an accept
// WWAIT  | write accepted, waiting one cycle for hwdata
// SETUP  | APB setup phase, pselx driven, penable=0
// ACCESS | APB access phase, penable=1, completes on pready
// ---------------------------------------------------------------------------
module apb_master_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    apb_master_controller_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WWAIT  = 2'd1,
        ST_SETUP  = 2'd2,
        ST_ACCESS = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr_q;
    logic [NSEL-1:0]   r_sel_q;
    logic [NSEL-1:0]   r_pselx;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;

    logic              w_pready_ok;
    logic              w_hreadyout;
    logic              w_accept;

`ifdef APB_PREADY_EN
    assign w_pready_ok = bus.pready;
`else
    logic w_unused_pready;
    assign w_unused_pready = bus.pready;
    assign w_pready_ok     = 1'b1;
`endif

    always_comb begin
        w_hreadyout = 1'b0;
        case (r_state)
            ST_IDLE:   w_hreadyout = 1'b1;
            ST_ACCESS: w_hreadyout = w_pready_ok;
            default:   w_hreadyout = 1'b0;
        endcase
    end

    // hreadyout is only high in IDLE or a completing ACCESS, so this also
    // filters out any valid seen while a transfer is still in flight.
    assign w_accept = bus.valid && w_hreadyout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr_q  <= '0;
            r_sel_q   <= '0;
            r_pselx   <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            case (r_state)
                ST_WWAIT: begin
                    r_state  <= ST_SETUP;
                    r_paddr  <= r_addr_q;
                    r_pselx  <= r_sel_q;
                    r_pwrite <= 1'b1;
                    r_pwdata <= bus.hwdata;
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (w_pready_ok) begin
                        r_state   <= ST_IDLE;
                        r_pselx   <= '0;
                        r_penable <= 1'b0;
                    end
                end
                default: ;
            endcase

            // A new transfer accepted in a completing ACCESS overrides the
            // return to IDLE above.
            if (w_accept) begin
                r_penable <= 1'b0;
                if (bus.hwrite) begin
                    r_state  <= ST_WWAIT;
                    r_addr_q <= bus.haddr;
                    r_sel_q  <= bus.tempselx;
                    r_pselx  <= '0;
                end else begin
                    r_state  <= ST_SETUP;
                    r_paddr  <= bus.haddr;
                    r_pselx  <= bus.tempselx;
                    r_pwrite <= 1'b0;
                end
            end
        end
    end

    assign bus.hreadyout = w_hreadyout;
    assign bus.pselx     = r_pselx;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master_controller.sv
module tb_apb_master_controller;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NSEL   = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    apb_master_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL)) bus_if ();

    apb_master_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s, input logic p);
        rst             = r;
        bus_if.valid    = v;
        bus_if.hwrite   = w;
        bus_if.haddr    = a;
        bus_if.hwdata   = d;
        bus_if.tempselx = s;
        bus_if.pready   = p;
    endtask

    task automatic chk_outputs(input string tag, input logic e_hr, input logic [2:0] e_sel,
                               input logic e_pen, input logic e_pwr, input logic [31:0] e_addr,
                               input logic [31:0] e_data);
        chk({tag, ".hreadyout"}, 64'(bus_if.hreadyout), 64'(e_hr));
        chk({tag, ".pselx"},     64'(bus_if.pselx),     64'(e_sel));
        chk({tag, ".penable"},   64'(bus_if.penable),   64'(e_pen));
        chk({tag, ".pwrite"},    64'(bus_if.pwrite),    64'(e_pwr));
        chk({tag, ".paddr"},     64'(bus_if.paddr),     64'(e_addr));
        chk({tag, ".pwdata"},    64'(bus_if.pwdata),    64'(e_data));
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: inputs applied for one cycle; expected outputs are
    // those seen during that cycle (before the closing rising edge).
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        valid;
        logic        hwrite;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [2:0]  tsel;
        logic        pready;
        logic        e_hr;
        logic [2:0]  e_sel;
        logic        e_pen;
        logic        e_pwr;
        logic [31:0] e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] s, input logic p,
                                input logic e_hr, input logic [2:0] e_sel, input logic e_pen,
                                input logic e_pwr, input logic [31:0] e_addr, input logic [31:0] e_data);
        vec_t x;
        x.rst = r; x.valid = v; x.hwrite = w; x.haddr = a; x.hwdata = d; x.tsel = s; x.pready = p;
        x.e_hr = e_hr; x.e_sel = e_sel; x.e_pen = e_pen; x.e_pwr = e_pwr;
        x.e_addr = e_addr; x.e_data = e_data;
        vecs.push_back(x);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: tracks a transfer by its age in cycles since the
    // accepting edge. Reads reach SETUP at age 1, writes at age 2; ACCESS
    // starts one cycle after SETUP and ends on the first ready cycle.
    // ------------------------------------------------------------------
    bit          m_busy;
    int          m_age;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [2:0]  m_sel;
    logic [31:0] m_paddr;
    logic        m_pwrite;
    logic [31:0] m_pwdata;

    function automatic logic ready_ok(input logic p);
`ifdef APB_PREADY_EN
        return p;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int setup_age();
        return m_wr ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_wr = 0; m_addr = '0; m_sel = '0;
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
    endtask

    task automatic model_out(input logic p, output logic e_hr, output logic [2:0] e_sel,
                             output logic e_pen);
        bit in_access;
        in_access = m_busy && (m_age >= setup_age() + 1);
        if (!m_busy)        e_hr = 1'b1;
        else if (in_access) e_hr = ready_ok(p);
        else                e_hr = 1'b0;
        e_pen = in_access;
        e_sel = (m_busy && m_age >= setup_age()) ? m_sel : 3'b000;
    endtask

    task automatic model_step(input logic r, input logic v, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] s, input logic p);
        logic e_hr, e_pen;
        logic [2:0] e_sel;
        if (r) begin
            model_reset();
            return;
        end
        model_out(p, e_hr, e_sel, e_pen);
        if (m_busy) begin
            if (e_pen && ready_ok(p)) begin
                m_busy = 0;
            end else begin
                m_age++;
                if (m_wr && m_age == 2) begin
                    m_paddr  = m_addr;
                    m_pwrite = 1'b1;
                    m_pwdata = d;
                end
            end
        end
        if (v && e_hr) begin
            m_busy = 1; m_age = 1; m_wr = w; m_addr = a; m_sel = s;
            if (!w) begin
                m_paddr  = a;
                m_pwrite = 1'b0;
            end
        end
    endtask

    // Accept a transfer, stall ACCESS for nwait cycles, and count cycles from
    // the accepting edge to the first hreadyout=1.
    task automatic measure(input logic wr, input int nwait, input int exp_lat, input string tag);
        int cyc;
        int stall;
        bit done;
        @(negedge clk);
        drive(0, 1, wr, 32'h8000_0040, 32'hA5A5_0000 + nwait, 3'b100, 1'b1);
        @(posedge clk);
        cyc = 0; stall = 0; done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus_if.penable === 1'b1 && stall < nwait) begin
                drive(0, 0, 0, 32'h0, 32'hA5A5_0000 + nwait, 3'b000, 1'b0);
                stall++;
            end else begin
                drive(0, 0, 0, 32'h0, 32'hA5A5_0000 + nwait, 3'b000, 1'b1);
            end
            #1;
            if (bus_if.hreadyout === 1'b1 && cyc > 0) done = 1;
        end
        chk({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 32'h0, 3'b000, 1'b1);
        #1;
        chk({tag, ".idle_after"}, 64'({bus_if.hreadyout, bus_if.penable, bus_if.pselx}), 64'(5'b10000));
    endtask

    int extra_wait;

    initial begin
        drive(1, 0, 0, 32'h0, 32'h0, 3'b000, 1'b1);
        model_reset();

        //  rst v w haddr         hwdata        sel     rdy  hr sel     pen pwr paddr         pwdata
        add(0, 1, 0, 32'h8400_0010, 32'h0,        3'b010, 1,   1, 3'b000, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 1,   0, 3'b010, 0, 0, 32'h8400_0010, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 1,   1, 3'b010, 1, 0, 32'h8400_0010, 32'h0);
        add(0, 1, 1, 32'h8000_0004, 32'h0,        3'b001, 1,   1, 3'b000, 0, 0, 32'h8400_0010, 32'h0);
        add(0, 0, 0, 32'h0,        32'hDEAD_BEEF, 3'b000, 1,   0, 3'b000, 0, 0, 32'h8400_0010, 32'h0);
        add(0, 0, 0, 32'h0,        32'hDEAD_BEEF, 3'b000, 1,   0, 3'b001, 0, 1, 32'h8000_0004, 32'hDEAD_BEEF);
        add(0, 1, 0, 32'h8800_0000, 32'h0,        3'b100, 1,   1, 3'b001, 1, 1, 32'h8000_0004, 32'hDEAD_BEEF);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 1,   0, 3'b100, 0, 0, 32'h8800_0000, 32'hDEAD_BEEF);
        add(0, 1, 1, 32'h8000_0008, 32'h0,        3'b001, 1,   1, 3'b100, 1, 0, 32'h8800_0000, 32'hDEAD_BEEF);
        add(0, 0, 0, 32'h0,        32'h1234_5678, 3'b000, 1,   0, 3'b000, 0, 0, 32'h8800_0000, 32'hDEAD_BEEF);
        add(0, 0, 0, 32'h0,        32'h1234_5678, 3'b000, 1,   0, 3'b001, 0, 1, 32'h8000_0008, 32'h1234_5678);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 1,   1, 3'b001, 1, 1, 32'h8000_0008, 32'h1234_5678);
        add(0, 1, 0, 32'h8400_0020, 32'h0,        3'b010, 1,   1, 3'b000, 0, 1, 32'h8000_0008, 32'h1234_5678);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 1,   0, 3'b010, 0, 0, 32'h8400_0020, 32'h1234_5678);
        add(1, 0, 0, 32'h0,        32'h0,        3'b000, 1,   1, 3'b010, 1, 0, 32'h8400_0020, 32'h1234_5678);
        add(1, 0, 0, 32'h0,        32'h0,        3'b000, 1,   1, 3'b000, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 1,   1, 3'b000, 0, 0, 32'h0,        32'h0);
`ifdef APB_PREADY_EN
        add(0, 1, 0, 32'h8400_0010, 32'h0,        3'b010, 1,   1, 3'b000, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 0,   0, 3'b010, 0, 0, 32'h8400_0010, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 0,   0, 3'b010, 1, 0, 32'h8400_0010, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 0,   0, 3'b010, 1, 0, 32'h8400_0010, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 0,   0, 3'b010, 1, 0, 32'h8400_0010, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 1,   1, 3'b010, 1, 0, 32'h8400_0010, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 1,   1, 3'b000, 0, 0, 32'h8400_0010, 32'h0);
`else
        add(0, 1, 0, 32'h8400_0010, 32'h0,        3'b010, 0,   1, 3'b000, 0, 0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 0,   0, 3'b010, 0, 0, 32'h8400_0010, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 0,   1, 3'b010, 1, 0, 32'h8400_0010, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        3'b000, 0,   1, 3'b000, 0, 0, 32'h8400_0010, 32'h0);
`endif

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].valid, vecs[i].hwrite, vecs[i].haddr, vecs[i].hwdata,
                  vecs[i].tsel, vecs[i].pready);
            #1;
            chk_outputs($sformatf("vec%0d", i), vecs[i].e_hr, vecs[i].e_sel, vecs[i].e_pen,
                        vecs[i].e_pwr, vecs[i].e_addr, vecs[i].e_data);
        end

`ifdef APB_PREADY_EN
        extra_wait = 1;
`else
        extra_wait = 0;
`endif
        measure(0, 0, 2,                  "lat_rd0");
        measure(1, 0, 3,                  "lat_wr0");
        measure(0, 5, 2 + 5 * extra_wait, "lat_rd5");
        measure(1, 2, 3 + 2 * extra_wait, "lat_wr2");

        // Randomized run against the reference model.
        @(negedge clk);
        drive(1, 0, 0, 32'h0, 32'h0, 3'b000, 1'b1);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        r, v, w, p;
            logic [31:0] a, d;
            logic [2:0]  s;
            logic        e_hr, e_pen;
            logic [2:0]  e_sel;
            @(negedge clk);
            r = ($urandom_range(0, 99) == 0);
            v = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            d = $urandom;
            s = 3'b001 << $urandom_range(0, 2);
            if ($urandom_range(0, 19) == 0) s = 3'b000;
            p = ($urandom_range(0, 3) != 0);
            drive(r, v, w, a, d, s, p);
            #1;
            model_out(p, e_hr, e_sel, e_pen);
            chk_outputs($sformatf("rnd%0d", c), e_hr, e_sel, e_pen, m_pwrite, m_paddr, m_pwdata);
            model_step(r, v, w, a, d, s, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
